// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL lock sequencer: state encodings, the
// retry counter width and helpers for sizing the shared cycle counter.
package pll_seq_pkg;

  // Width of the state register and of the state_dbg port.
  localparam int STATE_W = 3;

  // Width of the retry counter. The retry limit can be at most 7.
  localparam int RETRY_W = 3;

  // Sequencer states. The encodings appear on state_dbg, so keep them stable.
  typedef enum logic [STATE_W-1:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABILIZE = 3'd2,
    ST_READY     = 3'd3,
    ST_FAILED    = 3'd4
  } seq_state_e;

  // Returns the largest of three cycle-count parameters.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // Counter width for a terminal count of n.
  // The counter only has to reach n-1, so $clog2(n) bits are enough.
  // Keep at least one bit so that degenerate parameter values still elaborate.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer that brings an asynchronous level into the clk domain.
// Both stages clear on reset, so a stale lock indication cannot leak across
// a reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] stage1_q;
  logic [WIDTH-1:0] stage2_q;

  // Shift the asynchronous input through two flops; stage1 may go metastable.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage1_q <= '0;
      stage2_q <= '0;
    end else begin
      stage1_q <= async_in;
      stage2_q <= stage1_q;
    end
  end

  assign sync_out = stage2_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer.
// It pulses the PLL reset, waits for lock with a timeout and a bounded
// number of retries, and requires a stable lock window before it declares
// the clocks ready. After that it watches for loss of lock.
// One shared counter times every state that needs timing.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES     = 32,
  parameter int STABLE_CYCLES  = 256,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES    = 7
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               pll_locked,
  input  logic               restart_req,
  output logic               pll_rst,
  output logic               clocks_ready,
  output logic               lock_lost,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_count,
  output logic [STATE_W-1:0] state_dbg
);

  // The counter is sized for the longest interval it has to time.
  localparam int CNT_MAX = max3(RST_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES);
  localparam int CNT_W   = cnt_width(CNT_MAX);

  // Terminal counts. Each state leaves on the edge where the counter
  // reads N-1, so that state lasts exactly N cycles.
  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [RETRY_W-1:0] RETRY_ONE = RETRY_W'(1);

  logic locked_s;

  seq_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               lock_lost_q, lock_lost_d;
  logic               pll_rst_q, pll_rst_d;
  logic               clocks_ready_q, clocks_ready_d;
  logic               fail_q, fail_d;

  // pll_locked is asynchronous to refclk. The FSM only ever looks at the
  // synchronized copy.
  sync_2ff #(
    .WIDTH (1)
  ) u_lock_sync (
    .clk      (refclk),
    .rst      (rst),
    .async_in (pll_locked),
    .sync_out (locked_s)
  );

  // Next-state logic. restart_req overrides every other transition,
  // including the lock-loss exit from READY, so no lock_lost pulse is
  // produced when it is asserted.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    retry_d     = retry_q;
    lock_lost_d = 1'b0;

    if (restart_req) begin
      state_d = ST_RESET_PLL;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_RESET_PLL: begin
          if (cnt_q == RST_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_d = ST_STABILIZE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            cnt_d = '0;
            if (retry_q == RETRY_LIMIT) begin
              state_d = ST_FAILED;
            end else begin
              state_d = ST_RESET_PLL;
              retry_d = retry_q + RETRY_ONE;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        ST_STABILIZE: begin
          // A lock glitch does not consume a retry. It restarts the wait
          // for lock, and the stability window starts over from zero.
          if (!locked_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = ST_READY;
            cnt_d   = '0;
            retry_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        ST_READY: begin
          cnt_d = '0;
          if (!locked_s) begin
            state_d     = ST_RESET_PLL;
            lock_lost_d = 1'b1;
          end
        end

        ST_FAILED: begin
          // Stays here until restart_req or rst arrives.
          cnt_d = '0;
        end

        default: begin
          state_d = ST_RESET_PLL;
          cnt_d   = '0;
          retry_d = '0;
        end
      endcase
    end
  end

  // Moore outputs are decoded from the next state and registered, so they
  // change on the same edge as the state register and do not glitch.
  always_comb begin
    pll_rst_d      = (state_d == ST_RESET_PLL) || (state_d == ST_FAILED);
    clocks_ready_d = (state_d == ST_READY);
    fail_d         = (state_d == ST_FAILED);
  end

  // State, counter, retry and output registers. Reset takes priority over
  // everything else.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q        <= ST_RESET_PLL;
      cnt_q          <= '0;
      retry_q        <= '0;
      lock_lost_q    <= 1'b0;
      pll_rst_q      <= 1'b1;
      clocks_ready_q <= 1'b0;
      fail_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      retry_q        <= retry_d;
      lock_lost_q    <= lock_lost_d;
      pll_rst_q      <= pll_rst_d;
      clocks_ready_q <= clocks_ready_d;
      fail_q         <= fail_d;
    end
  end

  assign pll_rst      = pll_rst_q;
  assign clocks_ready = clocks_ready_q;
  assign lock_lost    = lock_lost_q;
  assign fail         = fail_q;
  assign retry_count  = retry_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer.
// The bench uses small parameters so that every scenario runs in a few hundred
// cycles. A table of segments drives the inputs; each segment holds the
// inputs for n cycles and gives the expected state after each of those
// edges. Hand-written sequences then measure pulse widths and latencies.
module tb_pll_lock_sequencer;
  import pll_seq_pkg::*;

  localparam int RSTC = 4;
  localparam int STBC = 8;
  localparam int TOC  = 20;
  localparam int MAXR = 2;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       restart_req = 1'b0;
  logic       pll_rst;
  logic       clocks_ready;
  logic       lock_lost;
  logic       fail;
  logic [2:0] retry_count;
  logic [2:0] state_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 refclk = ~refclk;

  pll_lock_sequencer #(
    .RST_CYCLES     (RSTC),
    .STABLE_CYCLES  (STBC),
    .TIMEOUT_CYCLES (TOC),
    .MAX_RETRIES    (MAXR)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .restart_req  (restart_req),
    .pll_rst      (pll_rst),
    .clocks_ready (clocks_ready),
    .lock_lost    (lock_lost),
    .fail         (fail),
    .retry_count  (retry_count),
    .state_dbg    (state_dbg)
  );

  typedef struct {
    logic       r;
    logic       lk;
    logic       rq;
    int         n;
    seq_state_e st;
    logic [2:0] rc;
    logic       ll;
  } seg_t;

  // Observed outputs packed as {pll_rst, clocks_ready, lock_lost, fail, retry_count, state}.
  typedef logic [9:0] obs_t;

  seg_t tbl[$];
  obs_t exp_q[$];

  function automatic void add(input logic r, input logic lk, input logic rq, input int n,
                              input seq_state_e st, input logic [2:0] rc, input logic ll);
    seg_t s;
    s.r = r; s.lk = lk; s.rq = rq; s.n = n; s.st = st; s.rc = rc; s.ll = ll;
    tbl.push_back(s);
  endfunction

  function automatic obs_t expect_of(input seq_state_e st, input logic [2:0] rc, input logic ll);
    logic prst, crdy, fl;
    prst = (st == ST_RESET_PLL) || (st == ST_FAILED);
    crdy = (st == ST_READY);
    fl   = (st == ST_FAILED);
    return {prst, crdy, ll, fl, rc, 3'(st)};
  endfunction

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Drive one cycle and queue its expectation. After the edge, pop the
  // expectation and compare it with what the DUT presents.
  task automatic step(input logic r, input logic lk, input logic rq, input obs_t e, input string tag);
    obs_t got, want;
    rst = r; pll_locked = lk; restart_req = rq;
    exp_q.push_back(e);
    tick();
    got  = {pll_rst, clocks_ready, lock_lost, fail, retry_count, state_dbg};
    want = exp_q.pop_front();
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: in rst=%b lk=%b rq=%b got %b required %b", tag, r, lk, rq, got, want);
    end else begin
      $display("ok   %s: in rst=%b lk=%b rq=%b out %b", tag, r, lk, rq, got);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, k, pulses, bad_rdy;

    // Bring-up: reset, a 4-cycle pll_rst pulse, lock raised 3 cycles after pll_rst falls.
    add(1, 0, 0, 2, ST_RESET_PLL, 0, 0);
    add(0, 0, 0, 3, ST_RESET_PLL, 0, 0);
    add(0, 0, 0, 1, ST_WAIT_LOCK, 0, 0);
    add(0, 0, 0, 2, ST_WAIT_LOCK, 0, 0);
    add(0, 1, 0, 2, ST_WAIT_LOCK, 0, 0);
    add(0, 1, 0, 8, ST_STABILIZE, 0, 0);
    add(0, 1, 0, 3, ST_READY,     0, 0);
    // Lock lost in READY: a single lock_lost pulse, 4 cycles of pll_rst, then recovery.
    add(0, 0, 0, 2, ST_READY,     0, 0);
    add(0, 0, 0, 1, ST_RESET_PLL, 0, 1);
    add(0, 0, 0, 1, ST_RESET_PLL, 0, 0);
    add(0, 1, 0, 2, ST_RESET_PLL, 0, 0);
    add(0, 1, 0, 1, ST_WAIT_LOCK, 0, 0);
    add(0, 1, 0, 8, ST_STABILIZE, 0, 0);
    add(0, 1, 0, 3, ST_READY,     0, 0);
    // restart_req from READY, then a one-cycle lock glitch in the 5th STABILIZE cycle.
    add(0, 1, 1, 1, ST_RESET_PLL, 0, 0);
    add(0, 1, 0, 3, ST_RESET_PLL, 0, 0);
    add(0, 1, 0, 1, ST_WAIT_LOCK, 0, 0);
    add(0, 1, 0, 5, ST_STABILIZE, 0, 0);
    add(0, 0, 0, 1, ST_STABILIZE, 0, 0);
    add(0, 1, 0, 1, ST_STABILIZE, 0, 0);
    add(0, 1, 0, 1, ST_WAIT_LOCK, 0, 0);
    add(0, 1, 0, 8, ST_STABILIZE, 0, 0);
    add(0, 1, 0, 3, ST_READY,     0, 0);
    // restart_req on the same edge as the lock loss (no pulse), then no lock: two retries, then FAILED.
    add(0, 0, 0, 2, ST_READY,     0, 0);
    add(0, 0, 1, 1, ST_RESET_PLL, 0, 0);
    add(0, 0, 0, 3, ST_RESET_PLL, 0, 0);
    add(0, 0, 0, 20, ST_WAIT_LOCK, 0, 0);
    add(0, 0, 0, 4, ST_RESET_PLL, 1, 0);
    add(0, 0, 0, 20, ST_WAIT_LOCK, 1, 0);
    add(0, 0, 0, 4, ST_RESET_PLL, 2, 0);
    add(0, 0, 0, 20, ST_WAIT_LOCK, 2, 0);
    add(0, 0, 0, 3, ST_FAILED,    2, 0);
    add(0, 1, 0, 4, ST_FAILED,    2, 0);
    // restart_req in FAILED, then rst in the middle of STABILIZE, then a full re-bring-up.
    add(0, 1, 1, 1, ST_RESET_PLL, 0, 0);
    add(0, 1, 0, 3, ST_RESET_PLL, 0, 0);
    add(0, 1, 0, 1, ST_WAIT_LOCK, 0, 0);
    add(0, 1, 0, 3, ST_STABILIZE, 0, 0);
    add(1, 1, 0, 2, ST_RESET_PLL, 0, 0);
    add(0, 1, 0, 3, ST_RESET_PLL, 0, 0);
    add(0, 1, 0, 1, ST_WAIT_LOCK, 0, 0);
    add(0, 1, 0, 8, ST_STABILIZE, 0, 0);
    add(0, 1, 0, 2, ST_READY,     0, 0);
    // rst while READY with the lock dropping: no lock_lost pulse.
    add(1, 0, 0, 1, ST_RESET_PLL, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      for (int j = 0; j < tbl[i].n; j++) begin
        step(tbl[i].r, tbl[i].lk, tbl[i].rq, expect_of(tbl[i].st, tbl[i].rc, tbl[i].ll),
             $sformatf("seg%0d.%0d", i, j));
      end
    end

    // Measure the pll_rst pulse width after reset release, counting the
    // period that follows the last reset edge.
    rst = 1'b0; pll_locked = 1'b0; restart_req = 1'b0;
    n = 0;
    while (pll_rst && n < 50) begin
      n++;
      tick();
    end
    check("pll_rst_width", n, RSTC);

    // Count the edges from the first edge that samples lock high until clocks_ready rises.
    tick();
    tick();
    pll_locked = 1'b1;
    tick();
    k = 0;
    while (!clocks_ready && k < 50) begin
      tick();
      k++;
    end
    check("ready_latency", k, STBC + 2);
    check("retry_after_ready", int'(retry_count), 0);

    // On lock loss, lock_lost must pulse exactly once and clocks_ready must already be low.
    pll_locked = 1'b0;
    pulses = 0;
    bad_rdy = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (lock_lost) begin
        pulses++;
        if (clocks_ready) bad_rdy++;
      end
    end
    check("lock_lost_pulses", pulses, 1);
    check("ready_high_during_pulse", bad_rdy, 0);
    check("pll_rst_after_loss", int'(pll_rst), 0);
    check("state_after_loss", int'(state_dbg), int'(ST_WAIT_LOCK));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 SHALL have parameter RST_CYCLES, 32, cycles pll_rst is held high per reset attempt.
REQ-002 SHALL have parameter STABLE_CYCLES, 256, consecutive synchronized-lock cycles required before ready.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, 65536, cycles allowed in WAIT_LOCK before a retry.
REQ-004 SHALL have parameter MAX_RETRIES, 7, retries allowed before FAILED; maximum value 7.
REQ-005 SHALL have port refclk  in  1  sole clock; all logic rising-edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port pll_locked  in  1  PLL lock flag, asynchronous to refclk.
REQ-008 SHALL have port restart_req  in  1  single-cycle request to restart the lock sequence.
REQ-009 SHALL have port pll_rst  out  1  reset to the PLL.
REQ-010 SHALL have port clocks_ready  out  1  high while PLL outputs are usable.
REQ-011 SHALL have port lock_lost  out  1  one-cycle pulse on loss of lock in READY.
REQ-012 SHALL have port fail  out  1  high in FAILED.
REQ-013 SHALL have port retry_count  out  3  retries consumed in current attempt sequence.
REQ-014 SHALL have port state_dbg  out  3  current state encoding.

Function
REQ-015 SHALL pass pll_locked through a 2-flop synchronizer; FSM uses only the synchronized value (locked_s).
REQ-016 SHALL implement states RESET_PLL, WAIT_LOCK, STABILIZE, READY, FAILED with one shared counter sized $clog2 of the largest count parameter.
REQ-017 SHALL decode outputs from the state register (Moore): pll_rst=1 in RESET_PLL and FAILED; clocks_ready=1 only in READY; fail=1 only in FAILED.
REQ-018 RESET_PLL: counter increments each cycle; on edge where counter=RST_CYCLES-1, go WAIT_LOCK, counter cleared (pll_rst high exactly RST_CYCLES cycles).
REQ-019 WAIT_LOCK: locked_s=1 -> STABILIZE, counter cleared; else on counter=TIMEOUT_CYCLES-1: retry_count=MAX_RETRIES -> FAILED, otherwise retry_count+1 and -> RESET_PLL.
REQ-020 STABILIZE: locked_s=0 -> WAIT_LOCK, counter cleared, retry_count unchanged; counter=STABLE_CYCLES-1 with locked_s=1 -> READY.
REQ-021 Latency: READY entered STABLE_CYCLES+2 edges after first edge sampling pll_locked high, given uninterrupted lock.
REQ-022 Entering READY SHALL clear retry_count.
REQ-023 READY: locked_s=0 -> RESET_PLL, lock_lost=1 for exactly that transition cycle, clocks_ready low from the same edge.
REQ-024 FAILED SHALL be held until restart_req or rst.
REQ-025 restart_req=1 in any state SHALL force RESET_PLL, counter and retry_count cleared, overriding all other transitions; no lock_lost pulse in that case.
REQ-026 Priority: rst > restart_req > lock-loss/timeout/count transitions.

Reset
REQ-027 While rst=1 at an edge: state=RESET_PLL, counter=0, retry_count=0, synchronizer flops=0, lock_lost=0; hence pll_rst=1, clocks_ready=0, fail=0.
REQ-028 Reset mid-operation SHALL abandon the current state with no lock_lost pulse; sequence restarts with a full RST_CYCLES pulse after rst falls.

Structure
REQ-029 State encodings and state width SHALL live in shared package pll_seq_pkg.
REQ-030 Synchronizer SHALL be sub-module sync_2ff; FSM and counter stay in pll_lock_sequencer.

Verification (RST_CYCLES=4, STABLE_CYCLES=8, TIMEOUT_CYCLES=20, MAX_RETRIES=2)
REQ-031 Bring-up: release rst, raise pll_locked 3 cycles after pll_rst falls -> pll_rst high 4 cycles, clocks_ready rises 10 edges after pll_locked sampled high, retry_count=0.
REQ-032 Glitch: drop pll_locked 1 cycle during 5th STABILIZE cycle -> return to WAIT_LOCK, clocks_ready stays 0, READY only after 8 fresh consecutive lock cycles.
REQ-033 No lock: pll_locked=0 -> three 20-cycle WAIT_LOCK windows split by 4-cycle pll_rst pulses, retry_count 1 then 2, then FAILED: fail=1, pll_rst=1 held.
REQ-034 Loss in READY: drop pll_locked -> lock_lost single pulse, clocks_ready falls same edge, 4-cycle pll_rst, recovery to READY after re-lock.
REQ-035 restart_req in FAILED, and in READY coincident with lock loss -> RESET_PLL next edge, fail=0, retry_count=0, no lock_lost pulse.
REQ-036 rst asserted mid-STABILIZE -> next edge all outputs at reset values, pll_rst=1.
